// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-outstanding float issue sequencer between decode and the FPU.
// Flow: IDLE -> LAUNCH -> BUSY -> WB -> IDLE, plus sticky fflags accumulation.
// Optional BUSY watchdog: define FPU_ISSUE_TIMEOUT_EN to abort after TIMEOUT_CYCLES.
module fpu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [6:0]  issue_funct7,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic [2:0]  issue_frm,
    input  logic        issue_lw,
    input  logic        issue_sw,
    input  logic [31:0] issue_dload,
    input  logic [2:0]  csr_frm,
    input  logic        flush,
    input  logic        fflags_clr,
    input  logic        fpu_ready,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_flags,
    output logic        fpu_start,
    output logic [6:0]  fpu_funct7,
    output logic [4:0]  fpu_rs1,
    output logic [4:0]  fpu_rs2,
    output logic [4:0]  fpu_rd,
    output logic [2:0]  fpu_frm,
    output logic        fpu_lw,
    output logic        fpu_sw,
    output logic [31:0] fpu_dload,
    output logic        fpu_wen,
    output logic [31:0] store_data,
    output logic        store_valid,
    output logic        stall,
    output logic [4:0]  fflags,
    output logic        illegal_rm
);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, WB} state_t;

    state_t      r_state, w_next;
    logic        r_alive;
    logic [6:0]  r_funct7;
    logic [4:0]  r_rs1, r_rs2, r_rd;
    logic [2:0]  r_frm;
    logic        r_lw, r_sw;
    logic [31:0] r_dload, r_res;
    logic [4:0]  r_cflags, r_fflags;
    logic        r_illegal;

    logic        w_accept, w_rm_bad, w_timeout, w_start, w_wen, w_sv;
    logic [2:0]  w_rm;
    logic [4:0]  w_fl_set;

    // r_alive keeps issue_ready low while reset is held and for the release edge
    assign issue_ready = (r_state == IDLE) && !flush && r_alive;
    assign w_accept    = issue_valid && issue_ready;
    assign w_rm        = (issue_frm == 3'b111) ? csr_frm : issue_frm;
    assign w_rm_bad    = (w_rm >= 3'b101);

`ifdef FPU_ISSUE_TIMEOUT_EN
    logic [15:0] r_cnt;
    // BUSY watchdog: counts completed BUSY cycles, cleared whenever BUSY is left
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                                  r_cnt <= '0;
        else if (r_state == BUSY && w_next == BUSY)  r_cnt <= r_cnt + 16'd1;
        else                                         r_cnt <= '0;
    end
    assign w_timeout = (r_state == BUSY) && !flush && !fpu_ready &&
                       (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign w_timeout    = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_next;
            r_alive <= 1'b1;
        end
    end

    // next state and single-cycle strobes; flush suppresses every side effect
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_wen   = 1'b0;
        w_sv    = 1'b0;
        case (r_state)
            IDLE:   if (w_accept && !w_rm_bad) w_next = LAUNCH;
            LAUNCH: begin
                w_start = !flush;
                w_next  = flush ? IDLE : BUSY;
            end
            BUSY: begin
                if (flush)          w_next = IDLE;
                else if (fpu_ready) w_next = WB;
                else if (w_timeout) w_next = IDLE;
            end
            WB: begin
                w_next = IDLE;
                w_wen  = !flush && !r_sw;
                w_sv   = !flush && r_sw;
            end
            default: w_next = IDLE;
        endcase
    end

    // flags to OR into fflags this cycle (arith writeback, or NV on watchdog abort)
    always_comb begin
        w_fl_set = '0;
        if (r_state == WB && !flush && !r_lw && !r_sw) w_fl_set = r_cflags;
        if (w_timeout) w_fl_set = w_fl_set | 5'b10000;
    end

    // held instruction fields, captured FPU result/flags, and the rm-reject pulse
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_funct7  <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_frm     <= '0;
            r_lw      <= 1'b0;
            r_sw      <= 1'b0;
            r_dload   <= '0;
            r_res     <= '0;
            r_cflags  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && w_rm_bad;
            if (w_accept) begin
                r_funct7 <= issue_funct7;
                r_rs1    <= issue_rs1;
                r_rs2    <= issue_rs2;
                r_rd     <= issue_rd;
                r_frm    <= w_rm;
                r_lw     <= issue_lw;
                r_sw     <= issue_sw;
                r_dload  <= issue_dload;
            end
            if (r_state == BUSY && fpu_ready && !flush) begin
                r_res    <= fpu_result;
                r_cflags <= fpu_flags;
            end
        end
    end

    // sticky flags: a same-cycle clear is applied before the new flags are ORed in
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_fflags <= '0;
        else        r_fflags <= (fflags_clr ? 5'b0 : r_fflags) | w_fl_set;
    end

    assign fpu_start   = w_start;
    assign fpu_wen     = w_wen;
    assign store_valid = w_sv;
    assign stall       = (r_state != IDLE);
    assign fpu_funct7  = r_funct7;
    assign fpu_rs1     = r_rs1;
    assign fpu_rs2     = r_rs2;
    assign fpu_rd      = r_rd;
    assign fpu_frm     = r_frm;
    assign fpu_lw      = r_lw;
    assign fpu_sw      = r_sw;
    assign fpu_dload   = r_dload;
    assign store_data  = r_res;
    assign fflags      = r_fflags;
    assign illegal_rm  = r_illegal;

endmodule
